cursor_move_ctrl: RTL and testbench

//  Upstream of the cursor_sqr overlay: turns the four DE1-SoC pushbuttons into a grid cursor (col,row).

---
 rtl/minesweeper_pkg.sv | 40 ++++
 rtl/cursor_move_ctrl_if.sv | 23 ++
 rtl/key_debounce.sv | 81 ++++++++
 rtl/cursor_move_ctrl.sv | 105 ++++++++++
 tb/tb_cursor_move_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
// Shared types and default grid constants for the minesweeper cursor path.
package minesweeper_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_RIGHT,
    DIR_LEFT,
    DIR_DOWN,
    DIR_UP
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    HELD,
    REL_CNT
  } deb_state_t;

  localparam int unsigned DEF_GRID_COLS       = 8;
  localparam int unsigned DEF_GRID_ROWS       = 8;
  localparam int unsigned DEF_CELL_PX         = 40;
  localparam int unsigned DEF_GRID_X0         = 160;
  localparam int unsigned DEF_GRID_Y0         = 80;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned KEY_NUM             = 4;
  localparam int unsigned COORD_W             = 4;
  localparam int unsigned PIX_W               = 10;

  // Same-cycle presses resolve right > left > down > up (key index order).
  function automatic dir_t pick_dir(input logic [KEY_NUM-1:0] press);
    dir_t d;
    d = DIR_NONE;
    if (press[0])      d = DIR_RIGHT;
    else if (press[1]) d = DIR_LEFT;
    else if (press[2]) d = DIR_DOWN;
    else if (press[3]) d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/cursor_move_ctrl_if.sv
// Button/vsync inputs and cursor outputs of cursor_move_ctrl.
interface cursor_move_ctrl_if;
  import minesweeper_pkg::*;

  logic [KEY_NUM-1:0] key_n;
  logic               vga_vs;
  logic [COORD_W-1:0] cur_col;
  logic [COORD_W-1:0] cur_row;
  logic [PIX_W-1:0]   sqr_x0;
  logic [PIX_W-1:0]   sqr_y0;
  logic               move_pending;
  logic               moved;

  modport master (
    output key_n, vga_vs,
    input  cur_col, cur_row, sqr_x0, sqr_y0, move_pending, moved
  );

  modport slave (
    input  key_n, vga_vs,
    output cur_col, cur_row, sqr_x0, sqr_y0, move_pending, moved
  );
endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce FSM, single press pulse per press.
module key_debounce
  import minesweeper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             key_low;

  assign key_low = ~sync_q[1];
  assign press_o = press_q;

  // Synchroniser, state, counter and pulse registers; released key is the reset level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Debounce next-state: require a stable level for DEBOUNCE_CYCLES in both directions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_low) begin
          state_d = PRESS_CNT;
          cnt_d   = '0;
        end
      end
      PRESS_CNT: begin
        if (!key_low) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_low) begin
          state_d = REL_CNT;
          cnt_d   = '0;
        end
      end
      REL_CNT: begin
        if (key_low) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Grid cursor driven by the four pushbuttons, moves committed on VS falling edge.
// Optional feature: define CURSOR_WRAP_EN to wrap at grid edges (default saturates).
module cursor_move_ctrl
  import minesweeper_pkg::*;
#(
  parameter int unsigned GRID_COLS       = DEF_GRID_COLS,
  parameter int unsigned GRID_ROWS       = DEF_GRID_ROWS,
  parameter int unsigned CELL_PX         = DEF_CELL_PX,
  parameter int unsigned GRID_X0         = DEF_GRID_X0,
  parameter int unsigned GRID_Y0         = DEF_GRID_Y0,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input logic             clk,
  input logic             rst,
  cursor_move_ctrl_if.slave bus
);

`ifdef CURSOR_WRAP_EN
  localparam logic EDGE_WRAP = 1'b1;
`else
  localparam logic EDGE_WRAP = 1'b0;
`endif

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(GRID_COLS - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(GRID_ROWS - 1);

  logic [KEY_NUM-1:0] press;
  logic [COORD_W-1:0] cur_col_q, cur_col_d, cur_row_q, cur_row_d;
  logic [PIX_W-1:0]   sqr_x0_q, sqr_x0_d, sqr_y0_q, sqr_y0_d;
  logic               pend_q, pend_d, moved_q, moved_d, vs_q;
  dir_t               dir_q, dir_d;
  logic               commit;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (bus.key_n[k]),
      .press_o (press[k])
    );
  end

  assign commit           = vs_q & ~bus.vga_vs & pend_q;
  assign bus.cur_col      = cur_col_q;
  assign bus.cur_row      = cur_row_q;
  assign bus.sqr_x0       = sqr_x0_q;
  assign bus.sqr_y0       = sqr_y0_q;
  assign bus.move_pending = pend_q;
  assign bus.moved        = moved_q;

  // Cursor, queue, VS history and pixel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
      sqr_x0_q  <= PIX_W'(GRID_X0);
      sqr_y0_q  <= PIX_W'(GRID_Y0);
      pend_q    <= 1'b0;
      moved_q   <= 1'b0;
      dir_q     <= DIR_NONE;
      vs_q      <= 1'b0;
    end else begin
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      sqr_x0_q  <= sqr_x0_d;
      sqr_y0_q  <= sqr_y0_d;
      pend_q    <= pend_d;
      moved_q   <= moved_d;
      dir_q     <= dir_d;
      vs_q      <= bus.vga_vs;
    end
  end

  // Queue a press, commit it at the frame edge, then derive pixel origin from the cell.
  always_comb begin
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    pend_d    = pend_q;
    dir_d     = dir_q;
    moved_d   = 1'b0;
    sqr_x0_d  = PIX_W'(GRID_X0 + 32'(cur_col_q) * CELL_PX);
    sqr_y0_d  = PIX_W'(GRID_Y0 + 32'(cur_row_q) * CELL_PX);

    if (commit) begin
      moved_d = 1'b1;
      pend_d  = |press;
      dir_d   = pick_dir(press);
      case (dir_q)
        DIR_RIGHT: cur_col_d = (cur_col_q == COL_MAX) ? (EDGE_WRAP ? '0 : COL_MAX)
                                                      : cur_col_q + COORD_W'(1);
        DIR_LEFT:  cur_col_d = (cur_col_q == '0) ? (EDGE_WRAP ? COL_MAX : '0)
                                                 : cur_col_q - COORD_W'(1);
        DIR_DOWN:  cur_row_d = (cur_row_q == ROW_MAX) ? (EDGE_WRAP ? '0 : ROW_MAX)
                                                      : cur_row_q + COORD_W'(1);
        DIR_UP:    cur_row_d = (cur_row_q == '0) ? (EDGE_WRAP ? ROW_MAX : '0)
                                                 : cur_row_q - COORD_W'(1);
        default:   ;
      endcase
    end else if (!pend_q && (|press)) begin
      pend_d = 1'b1;
      dir_d  = pick_dir(press);
    end
  end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Directed bench for cursor_move_ctrl (DEBOUNCE_CYCLES=16).
module tb_cursor_move_ctrl;

`ifdef CURSOR_WRAP_EN
  localparam logic [3:0] EXP_COL_RIGHT_EDGE = 4'd0;
  localparam logic [3:0] EXP_ROW_UP_EDGE    = 4'd7;
  localparam logic [3:0] EXP_COL_AFTER_LEFT = 4'd7;
  localparam logic [9:0] EXP_Y_UP_EDGE      = 10'd360;
  localparam logic [9:0] EXP_X_AFTER_LEFT   = 10'd440;
`else
  localparam logic [3:0] EXP_COL_RIGHT_EDGE = 4'd7;
  localparam logic [3:0] EXP_ROW_UP_EDGE    = 4'd0;
  localparam logic [3:0] EXP_COL_AFTER_LEFT = 4'd6;
  localparam logic [9:0] EXP_Y_UP_EDGE      = 10'd80;
  localparam logic [9:0] EXP_X_AFTER_LEFT   = 10'd400;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  cursor_move_ctrl_if bus ();

  cursor_move_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.key_n  = 4'hF;
    bus.vga_vs = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  // Hold the masked keys low long enough to debounce, then release long enough to settle.
  task automatic press_keys(input logic [3:0] mask);
    bus.key_n = ~mask;
    tick(30);
    bus.key_n = 4'hF;
    tick(30);
  endtask

  // Drive VS low; returns one cycle later, when a commit is visible.
  task automatic vs_fall();
    bus.vga_vs = 1'b0;
    tick(1);
  endtask

  task automatic vs_restore();
    bus.vga_vs = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1; bus.key_n = 4'hF; bus.vga_vs = 1'b1;
    tick(3);
    n_cmp++; if (bus.cur_col !== 4'd0) begin n_fail++; $display("FAIL reset_col got %0d exp 0", bus.cur_col); end
    n_cmp++; if (bus.cur_row !== 4'd0) begin n_fail++; $display("FAIL reset_row got %0d exp 0", bus.cur_row); end
    n_cmp++; if (bus.sqr_x0 !== 10'd160) begin n_fail++; $display("FAIL reset_x0 got %0d exp 160", bus.sqr_x0); end
    n_cmp++; if (bus.sqr_y0 !== 10'd80) begin n_fail++; $display("FAIL reset_y0 got %0d exp 80", bus.sqr_y0); end
    n_cmp++; if (bus.move_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", bus.move_pending); end
    n_cmp++; if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved got %b exp 0", bus.moved); end
    bus.key_n[0] = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(12);
    n_cmp++; if (bus.move_pending !== 1'b0) begin n_fail++; $display("FAIL reset_early_pending got %b exp 0", bus.move_pending); end
    cyc = 12;
    while (bus.move_pending !== 1'b1 && cyc < 60) begin tick(1); cyc++; end
    n_cmp++; if (bus.move_pending !== 1'b1) begin n_fail++; $display("FAIL reset_held_press pending got %b exp 1", bus.move_pending); end
    n_cmp++; if (cyc < 16) begin n_fail++; $display("FAIL reset_held_latency got %0d exp >=16", cyc); end
    bus.key_n = 4'hF;
    tick(30);
    vs_fall();
    n_cmp++; if (bus.cur_col !== 4'd1) begin n_fail++; $display("FAIL reset_held_col got %0d exp 1", bus.cur_col); end
    vs_restore();
    vs_fall();
    n_cmp++; if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL reset_held_single got moved=%b exp 0", bus.moved); end
    vs_restore();
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(5);
    end
    n_cmp++; if (bus.move_pending !== 1'b0) begin n_fail++; $display("FAIL bounce_pending got %b exp 0", bus.move_pending); end
    press_keys(4'b0001);
    n_cmp++; if (bus.move_pending !== 1'b1) begin n_fail++; $display("FAIL bounce_settled got %b exp 1", bus.move_pending); end
    vs_fall();
    n_cmp++; if (bus.cur_col !== 4'd1) begin n_fail++; $display("FAIL bounce_col got %0d exp 1", bus.cur_col); end
    n_cmp++; if (bus.moved !== 1'b1) begin n_fail++; $display("FAIL bounce_moved got %b exp 1", bus.moved); end
    vs_restore();
    n_cmp++; if (bus.sqr_x0 !== 10'd200) begin n_fail++; $display("FAIL bounce_x0 got %0d exp 200", bus.sqr_x0); end
    n_cmp++; if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL bounce_moved_pulse got %b exp 0", bus.moved); end
    vs_fall();
    n_cmp++; if (bus.moved !== 1'b0 || bus.cur_col !== 4'd1) begin
      n_fail++; $display("FAIL bounce_second_vs got moved=%b col=%0d exp moved=0 col=1", bus.moved, bus.cur_col);
    end
    vs_restore();
  endtask

  task automatic test_frame_sync();
    do_reset();
    press_keys(4'b0001);
    tick(1000);
    n_cmp++; if (bus.cur_col !== 4'd0) begin n_fail++; $display("FAIL frame_wait_col got %0d exp 0", bus.cur_col); end
    n_cmp++; if (bus.move_pending !== 1'b1) begin n_fail++; $display("FAIL frame_wait_pending got %b exp 1", bus.move_pending); end
    vs_fall();
    n_cmp++; if (bus.cur_col !== 4'd1) begin n_fail++; $display("FAIL frame_commit_col got %0d exp 1", bus.cur_col); end
    n_cmp++; if (bus.moved !== 1'b1) begin n_fail++; $display("FAIL frame_commit_moved got %b exp 1", bus.moved); end
    n_cmp++; if (bus.move_pending !== 1'b0) begin n_fail++; $display("FAIL frame_commit_pending got %b exp 0", bus.move_pending); end
    vs_restore();
  endtask

  task automatic test_priority_drop();
    do_reset();
    press_keys(4'b0101);
    vs_fall();
    n_cmp++; if (bus.cur_col !== 4'd1 || bus.cur_row !== 4'd0) begin
      n_fail++; $display("FAIL prio_pos got col=%0d row=%0d exp col=1 row=0", bus.cur_col, bus.cur_row);
    end
    vs_restore();
    press_keys(4'b0001);
    press_keys(4'b0100);
    vs_fall();
    n_cmp++; if (bus.cur_col !== 4'd2 || bus.cur_row !== 4'd0) begin
      n_fail++; $display("FAIL drop_pos got col=%0d row=%0d exp col=2 row=0", bus.cur_col, bus.cur_row);
    end
    vs_restore();
    vs_fall();
    n_cmp++; if (bus.moved !== 1'b0 || bus.cur_row !== 4'd0) begin
      n_fail++; $display("FAIL drop_not_queued got moved=%b row=%0d exp moved=0 row=0", bus.moved, bus.cur_row);
    end
    vs_restore();
  endtask

  task automatic test_edges();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      press_keys(4'b0001);
      vs_fall();
      vs_restore();
    end
    n_cmp++; if (bus.cur_col !== 4'd7 || bus.sqr_x0 !== 10'd440) begin
      n_fail++; $display("FAIL edge_reach7 got col=%0d x0=%0d exp col=7 x0=440", bus.cur_col, bus.sqr_x0);
    end
    press_keys(4'b0001);
    vs_fall();
    n_cmp++; if (bus.cur_col !== EXP_COL_RIGHT_EDGE) begin
      n_fail++; $display("FAIL edge_right got %0d exp %0d", bus.cur_col, EXP_COL_RIGHT_EDGE);
    end
    n_cmp++; if (bus.moved !== 1'b1) begin n_fail++; $display("FAIL edge_right_moved got %b exp 1", bus.moved); end
    vs_restore();
    press_keys(4'b1000);
    vs_fall();
    n_cmp++; if (bus.cur_row !== EXP_ROW_UP_EDGE) begin
      n_fail++; $display("FAIL edge_up got %0d exp %0d", bus.cur_row, EXP_ROW_UP_EDGE);
    end
    n_cmp++; if (bus.moved !== 1'b1 || bus.move_pending !== 1'b0) begin
      n_fail++; $display("FAIL edge_up_flags got moved=%b pend=%b exp moved=1 pend=0", bus.moved, bus.move_pending);
    end
    vs_restore();
    n_cmp++; if (bus.sqr_y0 !== EXP_Y_UP_EDGE) begin
      n_fail++; $display("FAIL edge_up_y0 got %0d exp %0d", bus.sqr_y0, EXP_Y_UP_EDGE);
    end
    press_keys(4'b0010);
    vs_fall();
    vs_restore();
    n_cmp++; if (bus.cur_col !== EXP_COL_AFTER_LEFT || bus.sqr_x0 !== EXP_X_AFTER_LEFT) begin
      n_fail++; $display("FAIL edge_left got col=%0d x0=%0d exp col=%0d x0=%0d",
                         bus.cur_col, bus.sqr_x0, EXP_COL_AFTER_LEFT, EXP_X_AFTER_LEFT);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_keys(4'b0001);
    n_cmp++; if (bus.move_pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending_before got %b exp 1", bus.move_pending); end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    n_cmp++; if (bus.move_pending !== 1'b0) begin n_fail++; $display("FAIL mid_pending_after got %b exp 0", bus.move_pending); end
    vs_fall();
    n_cmp++; if (bus.moved !== 1'b0 || bus.cur_col !== 4'd0) begin
      n_fail++; $display("FAIL mid_no_move got moved=%b col=%0d exp moved=0 col=0", bus.moved, bus.cur_col);
    end
    vs_restore();
  endtask

  initial begin
    rst        = 1'b1;
    bus.key_n  = 4'hF;
    bus.vga_vs = 1'b1;
    test_reset();
    test_bounce();
    test_frame_sync();
    test_priority_drop();
    test_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
